serial_exec_core: RTL
=====================

Name: serial_exec_core

Overview:
Bit-serial execution core directly downstream of the DIP-switch instruction loader.
- Accepts one assembled instruction (4-bit opcode plus 12-bit instr field) per start pulse.
- Executes it LSB-first over WIDTH cycles against a 4-entry register file.
- Drives the 8-bit LED result register and carry/zero flags.

Parameters:
WIDTH, 8, datapath and register width in bits; must be ≥ 8; imm8 is zero-extended to WIDTH.

Ports:
clk     input   1      system clock
rst     input   1      asynchronous, active-high reset
start   input   1      one-cycle pulse: opcode/instr valid (loader's second button edge)
opcode  input   4      operation code
instr   input   12     operand fields: rd=[1:0], rs1=[3:2], rs2=[5:4], imm8=[11:4]
busy    output  1      high whenever state != IDLE
done    output  1      one-cycle pulse: result about to commit
out     output  8      LED result register (low 8 bits of the OUT source)
flag_c  output  1      carry/borrow flag
flag_z  output  1      zero flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, out=0, flag_c=0, flag_z=0, R0..R3=0, bit counter=0.
- rst asserted mid-execution aborts the instruction immediately; nothing is written back.
- States:
  - IDLE: start=1 at edge E0 latches opcode/instr, loads op_a=R[rs1] (R[rd] for ADDI), op_b=R[rs2] (imm8 for LDI/ADDI), clears res, inits carry (1 for SUB, 0 otherwise), sets z_acc=1 → EXEC.
  - EXEC: edges E1..E_WIDTH each process one bit.
    - a=op_a[0], b=op_b[0].
    - res shifts right with result bit in at MSB; op_a/op_b shift right.
    - carry updated; z_acc &= ~bit.
    - After the last bit → WB.
  - WB: done=1 for exactly this cycle. Next edge commits and returns to IDLE.
- Total latency: start edge to commit edge = WIDTH+1 edges; done visible in the cycle before commit.
- start while not IDLE (EXEC or WB) is ignored and dropped; no queueing.
- Opcodes and per-bit result:
  - 0 NOP: no writes.
  - 1 LDI: res=b.
  - 2 ADD: a+b.
  - 3 SUB: a+~b+1.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 SHL: bit=previous a (initial 0); carry=a[WIDTH-1].
  - 8 OUT: res=a, no regfile write.
  - 9 ADDI: R[rd]+imm8.
  - 10–15: treated as NOP.
- Commit:
  - Opcodes 1–7 and 9 write R[rd]=res.
  - OUT loads out=res[7:0].
  - flag_z=z_acc for every opcode except NOP/illegal (flags held).
  - flag_c=final carry for ADD/SUB/ADDI/SHL; flag_c=0 for logic ops/LDI/OUT.
  - SUB carry=1 means no borrow.
- Overflow wraps modulo 2^WIDTH.
- rd equal to rs1 and/or rs2 is legal: operands are copied at E0, so the old values are used.
- Registers are never written during EXEC.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_NOP..OP_ADDI)
  - instr field LSB/MSB constants
  - state encodings IDLE/EXEC/WB (2-bit localparams)
- Sub-module serial_alu: one-bit slice.
  - Inputs: a, b, op, carry_in. Outputs: res_bit, carry_out.
  - The carry register stays in the core.

Test Plan:
- LDI R1,0x5A (op=1, instr=0x5A1): busy high 9 cycles, done on cycle 9 → R1=0x5A, flag_z=0, flag_c=0; then OUT R1 (op=8, instr=0x004) → out=0x5A.
- LDI R2=0xF0, R3=0x20; ADD R0=R2+R3 (op=2, instr=0x02C... rs1=2, rs2=3, rd=0 → instr=0x038) → R0=0x10, flag_c=1, flag_z=0.
- SUB R0=R1-R1 with R1=0x33 (instr=0x014) → R0=0x00, flag_z=1, flag_c=1; SUB 0x00-0x01 → 0xFF, flag_c=0.
- SHL R1=0x81 in place (op=7, instr=0x005) → R1=0x02, flag_c=1; XOR R1^R1 → 0, flag_z=1.
- Second start pulse 3 cycles into ADD → ignored, result unchanged, exactly one done pulse; illegal opcode 0xC → no register or flag change, done pulses.
- rst asserted at cycle 4 of ADDI → all outputs 0 asynchronously, R[rd] left at 0, busy=0 after deassert.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, instruction field positions and FSM state encodings for the
// bit-serial execution core.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;

  localparam int RD_LSB  = 0;
  localparam int RD_MSB  = 1;
  localparam int RS1_LSB = 2;
  localparam int RS1_MSB = 3;
  localparam int RS2_LSB = 4;
  localparam int RS2_MSB = 5;
  localparam int IMM_LSB = 4;
  localparam int IMM_MSB = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Opcodes whose result lands in R[rd].
  function automatic logic op_writes_rf(input logic [3:0] op);
    return ((op >= OP_LDI) && (op <= OP_SHL)) || (op == OP_ADDI);
  endfunction

  // Opcodes that update flags at all (NOP and illegal codes hold them).
  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_ADDI);
  endfunction

  // Opcodes whose final carry is meaningful; the rest clear flag_c.
  function automatic logic op_keeps_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/serial_alu.sv
// One-bit ALU slice. For SHL the carry chain doubles as the "previous a bit"
// register, so the shifted-in bit is carry_in and carry_out is the current a.
module serial_alu
  import cpu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [3:0] op,
  input  logic       carry_in,
  output logic       res_bit,
  output logic       carry_out
);

  // Per-bit result and carry for every opcode; SUB uses the inverted b with
  // the carry pre-set to 1 by the core.
  always_comb begin
    res_bit   = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_LDI: res_bit = b;
      OP_ADD, OP_ADDI: begin
        res_bit   = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
      end
      OP_SUB: begin
        res_bit   = a ^ ~b ^ carry_in;
        carry_out = (a & ~b) | (a & carry_in) | (~b & carry_in);
      end
      OP_AND: res_bit = a & b;
      OP_OR:  res_bit = a | b;
      OP_XOR: res_bit = a ^ b;
      OP_SHL: begin
        res_bit   = carry_in;
        carry_out = a;
      end
      OP_OUT: res_bit = a;
      default: begin
        res_bit   = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_exec_core.sv
// Bit-serial execution core: latches one instruction per start pulse, runs it
// LSB-first over WIDTH cycles against a 4-entry register file, then commits
// the result, the LED register and the carry/zero flags in a single cycle.
module serial_exec_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [11:0] instr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  out,
  output logic        flag_c,
  output logic        flag_z
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_op;
  logic [1:0]         r_rd;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic               r_zacc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rf [4];
  logic [7:0]         r_out;
  logic               r_flag_c;
  logic               r_flag_z;

  logic [1:0]         w_rd;
  logic [1:0]         w_rs1;
  logic [1:0]         w_rs2;
  logic [7:0]         w_imm;
  logic               w_res_bit;
  logic               w_carry_out;
  logic               w_last;

  assign w_rd   = instr[RD_MSB:RD_LSB];
  assign w_rs1  = instr[RS1_MSB:RS1_LSB];
  assign w_rs2  = instr[RS2_MSB:RS2_LSB];
  assign w_imm  = instr[IMM_MSB:IMM_LSB];
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == WB);
  assign out    = r_out;
  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;

  serial_alu u_alu (
    .a         (r_op_a[0]),
    .b         (r_op_b[0]),
    .op        (r_op),
    .carry_in  (r_carry),
    .res_bit   (w_res_bit),
    .carry_out (w_carry_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: starts arriving outside IDLE are simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = EXEC;
      EXEC:    if (w_last) w_state_nxt = WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-bit execution and commit; operands are copied at
  // start so rd may alias rs1/rs2 and the register file only changes in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_NOP;
      r_rd     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_rd    <= w_rd;
            r_op_a  <= (opcode == OP_ADDI) ? r_rf[w_rd] : r_rf[w_rs1];
            r_op_b  <= ((opcode == OP_LDI) || (opcode == OP_ADDI)) ? WIDTH'(w_imm)
                                                                   : r_rf[w_rs2];
            r_res   <= '0;
            r_carry <= (opcode == OP_SUB);
            r_zacc  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        EXEC: begin
          r_res   <= {w_res_bit, r_res[WIDTH-1:1]};
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_carry <= w_carry_out;
          r_zacc  <= r_zacc & ~w_res_bit;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        WB: begin
          if (op_writes_rf(r_op)) r_rf[r_rd] <= r_res;
          if (r_op == OP_OUT) r_out <= r_res[7:0];
          if (op_sets_flags(r_op)) begin
            r_flag_z <= r_zacc;
            r_flag_c <= op_keeps_carry(r_op) ? r_carry : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
